write_ram: RTL and testbench

Write-side counterpart of the project's synchronous ROM readers: accepts a valid/ready data stream and stores it into an internal block RAM at consecutive addresses starting from a programmable base. It exposes a synchronous read port with the same one-cycle registered latency as the ROM readers, so display and sprite logic can read it in place of a ROM. Used to load or refresh image and tile data at runtime.

---
 rtl/write_ram_pkg.sv | 10 +
 rtl/write_ram_ram_dp.sv | 44 ++++
 rtl/write_ram.sv | 111 +++++++++++
 tb/tb_write_ram.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/write_ram_pkg.sv
// Shared types for the write_ram block: transfer FSM state encoding.
package write_ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/write_ram_ram_dp.sv
// Simple dual-port block RAM: one write port, one read port with a registered,
// read-first output. Only the output register is reset; contents are not.
module ram_dp #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Array read sees pre-write contents in the same cycle, giving read-first.
  always_comb begin
    rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/write_ram.sv
// Streams valid/ready words into a block RAM at consecutive (wrapping) addresses
// from a programmable base; exposes a ROM-compatible one-cycle read port.
module write_ram
  import write_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned WORDS      = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  busy,
  output logic                  done,
  input  logic [ADDR_WIDTH-1:0] addrB,
  output logic [DATA_WIDTH-1:0] doutB
);

  localparam int unsigned CNT_W = $clog2(WORDS + 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  armed_q, armed_d;
  logic                  din_ready_q, din_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  beat_c;

  // Next-state, address/count update and output decode from the next state.
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    cnt_d     = cnt_q;
    beat_c    = 1'b0;
    armed_d   = 1'b1;

    case (state_q)
      IDLE: begin
        // armed_q blocks a start sampled on the first edge after reset release.
        if (start && armed_q) begin
          state_d   = WRITE;
          wr_addr_d = base_addr;
          cnt_d     = '0;
        end
      end
      WRITE: begin
        if (din_valid) begin
          beat_c    = 1'b1;
          wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WORDS - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    din_ready_d = (state_d == WRITE);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_addr_q   <= '0;
      cnt_q       <= '0;
      armed_q     <= 1'b0;
      din_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      din_ready_q <= din_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign din_ready = din_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

  ram_dp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (beat_c),
    .waddr (wr_addr_q),
    .wdata (din),
    .raddr (addrB),
    .rdata (doutB)
  );

endmodule

// File: tb/tb_write_ram.sv
// Directed bench for write_ram (WORDS = 4): a bench-side memory model feeds a
// queue of expected read data that is checked as the read port answers.
module tb_write_ram;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 12;
  localparam int unsigned NW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic          busy;
  logic          done;
  logic [AW-1:0] addrB;
  logic [DW-1:0] doutB;

  logic [DW-1:0] model [4096];
  logic [DW-1:0] sb [$];
  int            n_assert = 0;
  int            n_fail   = 0;
  int            done_cnt = 0;

  write_ram #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .WORDS      (NW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .busy      (busy),
    .done      (done),
    .addrB     (addrB),
    .doutB     (doutB)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [DW-1:0] e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, doutB);
    end else begin
      e = sb.pop_front();
      check(tag, doutB, e);
    end
  endtask

  // Called at a negedge; returns at the negedge one cycle later.
  task automatic read_check(input logic [AW-1:0] a, input string tag);
    addrB = a;
    sb.push_back(model[a]);
    @(negedge clk);
    pop_check(tag);
  endtask

  task automatic xfer(input logic [AW-1:0] base, input logic [DW-1:0] d0,
                      input logic [3:0] pat, input bit mid_start, input bit collide);
    logic [AW-1:0] a;
    int            beats;
    int            cyc;
    int            dc0;
    bit            pending;
    logic          v;
    a = base; beats = 0; cyc = 0; pending = 0; dc0 = done_cnt;
    @(negedge clk);
    start = 1'b1; base_addr = base;
    @(negedge clk);
    start = 1'b0; base_addr = ~base;
    check("xfer_busy", 12'(busy), 12'd1);
    check("xfer_ready", 12'(din_ready), 12'd1);
    while (beats < int'(NW) && cyc < 64) begin
      if (pending) begin pop_check("collide_old"); pending = 0; end
      v = pat[cyc % 4];
      din_valid = v;
      din = d0 + DW'(beats);
      start = mid_start && (cyc == 1);
      if (v) begin
        if (collide) begin
          addrB = a;
          sb.push_back(model[a]);
          pending = 1;
        end
        model[a] = din;
        a = a + AW'(1);
        beats++;
      end else begin
        check("gap_busy", 12'(busy), 12'd1);
        check("gap_ready", 12'(din_ready), 12'd1);
      end
      cyc++;
      @(negedge clk);
    end
    if (pending) pop_check("collide_old");
    din_valid = 1'b0; start = 1'b0;
    check("done_pulse", 12'(done), 12'd1);
    check("done_ready", 12'(din_ready), 12'd0);
    check("done_busy", 12'(busy), 12'd1);
    @(negedge clk);
    check("post_done", 12'(done), 12'd0);
    check("post_busy", 12'(busy), 12'd0);
    check("done_once", 12'(done_cnt - dc0), 12'd1);
  endtask

  initial begin
    int dc;
    rst_n = 1'b0; start = 1'b1; base_addr = 12'h000;
    din = '0; din_valid = 1'b0; addrB = '0;

    // Reset values, then start held across release must be ignored.
    repeat (3) @(negedge clk);
    check("rst_ready", 12'(din_ready), 12'd0);
    check("rst_busy", 12'(busy), 12'd0);
    check("rst_done", 12'(done), 12'd0);
    check("rst_doutB", doutB, 12'd0);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("idle_ready", 12'(din_ready), 12'd0);
      check("idle_busy", 12'(busy), 12'd0);
      check("idle_done", 12'(done), 12'd0);
      @(negedge clk);
    end

    // Known neighbour contents at 0x014.., then basic load at 0x010.
    xfer(12'h014, 12'h5A5, 4'b1111, 0, 0);
    xfer(12'h010, 12'hA01, 4'b1111, 0, 0);
    for (int i = 0; i < 5; i++) read_check(AW'(12'h010 + i), "basic_rd");

    // Backpressure 1-0-0-1.
    xfer(12'h020, 12'h301, 4'b1001, 0, 0);
    for (int i = 0; i < 4; i++) read_check(AW'(12'h020 + i), "gap_rd");

    // Address wrap.
    xfer(12'hFFE, 12'h001, 4'b1111, 0, 0);
    read_check(12'hFFE, "wrap_ffe");
    read_check(12'hFFF, "wrap_fff");
    read_check(12'h000, "wrap_000");
    read_check(12'h001, "wrap_001");

    // Start pulsed mid-transfer, read-during-write at the write address.
    xfer(12'h010, 12'hB01, 4'b1111, 1, 1);
    for (int i = 0; i < 5; i++) read_check(AW'(12'h010 + i), "ovr_rd");

    // Reset after two of four beats.
    @(negedge clk);
    start = 1'b1; base_addr = 12'h100;
    @(negedge clk);
    start = 1'b0;
    din_valid = 1'b1; din = 12'hC01; model[12'h100] = 12'hC01;
    @(negedge clk);
    din = 12'hC02; model[12'h101] = 12'hC02;
    @(negedge clk);
    din_valid = 1'b0;
    dc = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 12'(din_ready), 12'd0);
    check("arst_busy", 12'(busy), 12'd0);
    check("arst_done", 12'(done), 12'd0);
    check("arst_doutB", doutB, 12'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_nodone", 12'(done_cnt - dc), 12'd0);
    check("arst_idle", 12'(busy), 12'd0);
    read_check(12'h100, "arst_rd0");
    read_check(12'h101, "arst_rd1");
    xfer(12'h100, 12'hD01, 4'b1111, 0, 0);
    for (int i = 0; i < 4; i++) read_check(AW'(12'h100 + i), "fresh_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
